spi_word_deserializer: RTL and testbench
========================================

// Module: spi_word_deserializer
// PURPOSE
//  SPI target-side receiver for the IMU data path: samples an external SPI bus (mode 0) in the system
//  clock domain and assembles MISO bits into WORD_W-bit words. Accepts any number of words per CS frame.
//  Buffers words in a FIFO with a valid/ready output toward the filter pipeline.
//  Flags aborted partial words and FIFO overflow. Generalised successor of serial_2_parallel.
// PARAMETERS
//  WORD_W       16  word width in bits; multiple of 8, range 8..32
//  FIFO_DEPTH   4   output FIFO entries; power of 2, >= 2
//  SYNC_STAGES  2   synchroniser flops on spi_sck/spi_cs_n/spi_miso; >= 2
//  CNT_W        8   width of frame_words counter
// PORTS
//  clk           in   1        system clock; f_clk >= 4*f_sck required
//  rst_n         in   1        asynchronous, active-low reset
//  spi_sck       in   1        SPI clock, idle low, async to clk
//  spi_cs_n      in   1        SPI chip select, active low, async
//  spi_miso      in   1        serial data, MSB first, stable at SCK rise
//  m_data        out  WORD_W   head-of-FIFO word
//  m_valid       out  1        FIFO non-empty
//  m_ready       in   1        consumer accepts m_data when m_valid & m_ready
//  frame_done    out  1        1-cycle pulse at CS deassert
//  frame_words   out  CNT_W    complete words in last frame; saturates at all-ones
//  partial_err   out  1        1-cycle pulse: CS deasserted mid-word
//  overflow      out  1        sticky: word dropped because FIFO full
//  clear_ovf     in   1        synchronous clear of overflow
// BEHAVIOUR
//  - Reset: m_valid=0, m_data=0, frame_done=0, frame_words=0, partial_err=0, overflow=0, FIFO empty,
//    bit counter 0, shift register 0, synchronisers 0 (cs_n sync reset to 1).
//  - All three SPI inputs pass through SYNC_STAGES flops. Edge detect on synced sck and synced cs_n.
//  - Bit capture: a synced sck rising edge while synced cs_n==0 shifts synced miso into the LSB.
//    It also increments bit_cnt (0..WORD_W-1). SCK edges while cs_n==1 are ignored.
//  - Word complete: on the edge where bit_cnt==WORD_W-1, push {shift[WORD_W-2:0],miso} and set
//    bit_cnt=0. The word goes through the optional swap. m_valid is high the next cycle.
//  - Latency, raw SCK rise to m_valid: <= SYNC_STAGES+2 clk.
//  - FIFO: push is accepted if not full. A push and a pop in the same cycle are both accepted when
//    full; occupancy is unchanged. When full with no pop, the word is dropped, overflow=1, and
//    contents are unchanged.
//  - m_data is combinational from the FIFO head. It holds stable while m_valid & !m_ready.
//  - overflow: set wins over clear_ovf in the same cycle.
//  - CS falling edge: bit_cnt=0, the shift register is cleared, and the internal word counter is cleared.
//  - CS rising edge: frame_done pulses, and frame_words takes the internal count.
//    If bit_cnt!=0, partial_err also pulses and the partial bits are discarded (no push).
//    A CS rise that coincides with word completion counts the word; partial_err stays 0.
//  - No state machine beyond IDLE (cs_n high) / ACTIVE (cs_n low), both decoded from synced cs_n.
//    A glitch-free CS is expected.
//  - Reset asserted mid-frame: all state clears immediately. After release, the block resyncs at
//    the next CS falling edge. SCK edges seen before that edge while cs_n is already low are not
//    captured.
// CONFIGURATION
//  SPI_DES_BYTE_SWAP_EN defined: pushed word has its byte order reversed (ISM330DHCX little-endian);
//    for WORD_W=16, data_out = {w[7:0],w[15:8]}.
//  Not defined: word pushed exactly as received, MSB-first.
// TESTING
//  1 Swap on, one frame with 0x1234 -> one push, m_data=0x3412, frame_words=1, partial_err=0.
//  2 Swap on, one frame with 0x1234 then 0x5678, m_ready=1 -> pops 0x3412 then 0x7856,
//    frame_words=2, one frame_done.
//  3 Swap off, 0x1234 -> m_data=0x1234. 8 SCK bits 0xAB then CS high -> partial_err pulse,
//    no push, frame_words=0.
//  4 m_ready=0, 5 words 0x0001..0x0005 -> overflow=1; pops return 0x0001..0x0004 only;
//    clear_ovf -> overflow=0.
//  5 Full FIFO, m_ready=1 on the same cycle as the 5th push -> no overflow, 0x0005 retained.
//  6 rst_n low after 7 bits -> all outputs 0. Next full frame of 0xBEEF -> correct single word.

Source files
------------

// File: rtl/spi_word_deserializer.sv
// SPI mode-0 target receiver: synchronises SCK/CS/MISO into clk, assembles WORD_W-bit words and
// queues them in a small FIFO with a valid/ready output. Optional byte swap: SPI_DES_BYTE_SWAP_EN.
module spi_word_deserializer #(
  parameter int WORD_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_miso,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_words,
  output logic              partial_err,
  output logic              overflow,
  input  logic              clear_ovf
);

  localparam int BW = $clog2(WORD_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, miso_sync;
  logic                   sck_d, cs_d, started, idle_ok;
  state_t                 state_q, state_d;
  logic [BW-1:0]          bit_cnt;
  logic [WORD_W-1:0]      shift_q, shifted, push_word;
  logic [CNT_W-1:0]       word_cnt, word_cnt_next;
  logic [WORD_W-1:0]      mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;

  // cs_n chain resets to idle so a reset never looks like the start of a frame.
  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      miso_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
      started   <= 1'b0;
      idle_ok   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      miso_sync <= {miso_sync[SYNC_STAGES-2:0], spi_miso};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
      started   <= 1'b1;
      idle_ok   <= idle_ok | (started & cs_sync[0]);
    end
  end

  logic sck_s, cs_s, miso_s, sck_rise, cs_fall, cs_rise;
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign miso_s   = miso_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  // A frame only starts once CS has been seen high after reset, so a bus that was
  // already mid-frame at reset release is ignored until its next real falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: defaults first so no path through always_comb leaves a latch behind.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall && idle_ok) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic active, capture, word_done, frame_end;
  assign active    = (state_q == ACTIVE);
  assign capture   = active & sck_rise;
  assign word_done = capture & (bit_cnt == LAST_BIT);
  assign frame_end = active & cs_rise;
  assign shifted   = {shift_q[WORD_W-2:0], miso_s};

`ifdef SPI_DES_BYTE_SWAP_EN
  always_comb begin
    push_word = '0;
    for (int i = 0; i < WORD_W / 8; i++)
      push_word[i*8 +: 8] = shifted[WORD_W-8-i*8 +: 8];
  end
`else
  assign push_word = shifted;
`endif

  always_comb begin
    word_cnt_next = word_cnt;
    if (word_done && word_cnt != '1) word_cnt_next = word_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      shift_q     <= '0;
      word_cnt    <= '0;
      frame_done  <= 1'b0;
      frame_words <= '0;
      partial_err <= 1'b0;
    end else begin
      frame_done  <= frame_end;
      partial_err <= frame_end & ~word_done & ((bit_cnt != '0) | capture);
      if (cs_fall) begin
        bit_cnt  <= '0;
        shift_q  <= '0;
        word_cnt <= '0;
      end else begin
        if (capture) begin
          shift_q  <= shifted;
          bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
          word_cnt <= word_cnt_next;
        end
        // Partial bits at CS release are discarded.
        if (frame_end) begin
          bit_cnt     <= '0;
          shift_q     <= '0;
          frame_words <= word_cnt_next;
        end
      end
    end
  end

  logic empty, full, pop, push_ok, ovf_set;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr - rd_ptr) == FULL_CNT);
  assign pop     = ~empty & m_ready;
  assign push_ok = word_done & (~full | pop);
  assign ovf_set = word_done & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (ovf_set)        overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  // NOTE: storage is not reset; empty-gating of m_data keeps unwritten entries invisible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  assign m_valid = ~empty;
  assign m_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_spi_word_deserializer.sv
// Directed bench for spi_word_deserializer: table of single-frame vectors plus hand-written
// multi-word, overflow, simultaneous push/pop and mid-frame reset sequences.
module tb_spi_word_deserializer;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n, spi_sck, spi_cs_n, spi_miso, m_ready, clear_ovf;
  logic [15:0] m_data;
  logic        m_valid, frame_done, partial_err, overflow;
  logic [7:0]  frame_words;

  spi_word_deserializer #(.WORD_W(16), .FIFO_DEPTH(4), .SYNC_STAGES(SYNC), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .frame_done(frame_done),
    .frame_words(frame_words), .partial_err(partial_err), .overflow(overflow),
    .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int pe_cnt = 0;
  int pop_n  = 0;
  logic [15:0] pop_log [64];

  always @(posedge clk) begin
    if (frame_done)  fd_cnt++;
    if (partial_err) pe_cnt++;
    if (rst_n && m_valid && m_ready) begin
      pop_log[pop_n % 64] = m_data;
      pop_n++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef SPI_DES_BYTE_SWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_miso = d[i];
      wait_n(4);
      spi_sck = 1'b1;
      wait_n(4);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_n(4);
  endtask

  task automatic cs_high();
    wait_n(4);
    spi_cs_n = 1'b1;
    wait_n(8);
  endtask

  task automatic pop_expect(input string name, input logic [15:0] exp);
    check({name, "_valid"}, 32'(m_valid), 32'd1);
    check(name, 32'(m_data), 32'(exp));
    m_ready = 1'b1;
    wait_n(1);
    m_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] data;
    int          nbits;
    logic        exp_push;
    logic [7:0]  exp_words;
    logic        exp_partial;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int fd0, pe0, pn0;
    vecs[0] = '{16'h1234, 16, 1'b1, 8'd1, 1'b0};
    vecs[1] = '{16'hFFFF, 16, 1'b1, 8'd1, 1'b0};
    vecs[2] = '{16'h0000, 16, 1'b1, 8'd1, 1'b0};
    vecs[3] = '{16'hA5C3, 16, 1'b1, 8'd1, 1'b0};
    vecs[4] = '{16'h00AB,  8, 1'b0, 8'd0, 1'b1};
    vecs[5] = '{16'h7FFF, 15, 1'b0, 8'd0, 1'b1};
    vecs[6] = '{16'h0000,  0, 1'b0, 8'd0, 1'b0};

    rst_n = 1'b0; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_miso = 1'b0;
    m_ready = 1'b0; clear_ovf = 1'b0;
    wait_n(4);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_words", 32'(frame_words), 0);
    check("rst_partial_err", 32'(partial_err), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    wait_n(6);

    // Single-frame vectors
    for (int v = 0; v < 7; v++) begin
      fd0 = fd_cnt; pe0 = pe_cnt;
      cs_low();
      send_bits(32'(vecs[v].data), vecs[v].nbits);
      cs_high();
      check($sformatf("vec%0d_valid", v), 32'(m_valid), 32'(vecs[v].exp_push));
      check($sformatf("vec%0d_words", v), 32'(frame_words), 32'(vecs[v].exp_words));
      check($sformatf("vec%0d_partial", v), 32'(pe_cnt - pe0), 32'(vecs[v].exp_partial));
      check($sformatf("vec%0d_done", v), 32'(fd_cnt - fd0), 32'd1);
      if (vecs[v].exp_push) pop_expect($sformatf("vec%0d_data", v), exp_word(vecs[v].data));
      check($sformatf("vec%0d_empty", v), 32'(m_valid), 32'd0);
    end

    // Two words in one frame, consumer always ready
    fd0 = fd_cnt; pn0 = pop_n;
    m_ready = 1'b1;
    cs_low();
    send_bits(32'h1234, 16);
    send_bits(32'h5678, 16);
    cs_high();
    m_ready = 1'b0;
    check("two_pops", 32'(pop_n - pn0), 32'd2);
    check("two_first", 32'(pop_log[pn0 % 64]), 32'(exp_word(16'h1234)));
    check("two_second", 32'(pop_log[(pn0 + 1) % 64]), 32'(exp_word(16'h5678)));
    check("two_words", 32'(frame_words), 32'd2);
    check("two_done", 32'(fd_cnt - fd0), 32'd1);

    // Overflow: five words, no consumer
    cs_low();
    for (int k = 1; k <= 5; k++) send_bits(32'(k), 16);
    cs_high();
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_words", 32'(frame_words), 32'd5);
    for (int k = 1; k <= 4; k++) pop_expect($sformatf("ovf_pop%0d", k), exp_word(16'(k)));
    check("ovf_drained", 32'(m_valid), 32'd0);
    clear_ovf = 1'b1;
    wait_n(1);
    clear_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO, pop coincides with the fifth push
    for (int k = 1; k <= 4; k++) begin
      cs_low();
      send_bits(32'(k), 16);
      cs_high();
    end
    check("full_no_ovf", 32'(overflow), 32'd0);
    pn0 = pop_n;
    cs_low();
    send_bits(32'h0002, 15);
    spi_miso = 1'b1;
    wait_n(4);
    spi_sck = 1'b1;
    wait_n(SYNC);
    m_ready = 1'b1;
    wait_n(1);
    m_ready = 1'b0;
    wait_n(4);
    spi_sck = 1'b0;
    cs_high();
    check("simul_ovf", 32'(overflow), 32'd0);
    check("simul_pops", 32'(pop_n - pn0), 32'd1);
    check("simul_popped", 32'(pop_log[pn0 % 64]), 32'(exp_word(16'h0001)));
    for (int k = 2; k <= 5; k++) pop_expect($sformatf("simul_pop%0d", k), exp_word(16'(k)));
    check("simul_drained", 32'(m_valid), 32'd0);

    // Reset after 7 bits of a frame
    cs_low();
    send_bits(32'h007F, 7);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_valid), 0);
    check("mid_rst_words", 32'(frame_words), 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    spi_cs_n = 1'b1;
    wait_n(4);
    rst_n = 1'b1;
    wait_n(6);
    check("post_rst_valid", 32'(m_valid), 0);
    check("post_rst_words", 32'(frame_words), 0);
    pe0 = pe_cnt;
    cs_low();
    send_bits(32'hBEEF, 16);
    cs_high();
    check("beef_words", 32'(frame_words), 32'd1);
    check("beef_partial", 32'(pe_cnt - pe0), 32'd0);
    pop_expect("beef_data", exp_word(16'hBEEF));
    check("beef_empty", 32'(m_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
